fetch_stage: RTL and testbench

//  IF stage: owns the PC, drives pc_o into instr_cache, captures the returned instr_i
//  and buffers {pc,instr} in a small FIFO toward decode with valid/ready handshake.

---
 rtl/fetch_stage.sv | 186 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction-fetch stage. Owns the program counter, presents it
//            to the instruction cache, captures the same-cycle instruction and
//            buffers {pc, instr, pred} in a small FIFO toward decode with a
//            valid/ready handshake. Redirects from EX flush the queue and
//            restart fetch at the new target.
// Options  : `define FETCH_BTFN_PRED_EN enables a static backward-taken /
//            forward-not-taken predictor for B-type branches. Without it,
//            fetch is strictly sequential and if_pred_taken_o is tied low.
// Ports    : clk_i            clock, all state on the rising edge
//            rst_i            synchronous active-high reset
//            pc_o             fetch address to the instruction cache
//            instr_i          instruction for pc_o, same cycle
//            redirect_i       flush queue and restart fetch at redirect_pc_i
//            redirect_pc_i    redirect target, bits [1:0] ignored
//            if_valid_o       queue head valid
//            if_ready_i       decode accepts the head this cycle
//            if_pc_o          PC of the head entry
//            if_instr_o       instruction of the head entry
//            if_pred_taken_o  head entry was predicted taken
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 2   // power of two, >= 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] pc_o,
  input  logic [31:0] instr_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        if_valid_o,
  input  logic        if_ready_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_instr_o,
  output logic        if_pred_taken_o
);

  localparam int unsigned PTR_W = $clog2(QDEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(QDEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [31:0]      INSTR_LEN = 32'd4;

  // --------------------------------------------------------------------------
  // Architectural state
  // --------------------------------------------------------------------------
  logic [31:0]      pc_q,     pc_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  // Queue storage is deliberately not reset: entries are only observable
  // once count marks them valid.
  logic [31:0] mem_pc_q    [QDEPTH];
  logic [31:0] mem_instr_q [QDEPTH];

  // --------------------------------------------------------------------------
  // Handshake / occupancy
  // --------------------------------------------------------------------------
  logic        q_empty;
  logic        q_full;
  logic        fetch_fire;
  logic        pop;
  logic [31:0] seq_pc;
  logic [31:0] next_pc;
  logic        pred_taken;

  assign q_empty = (count_q == '0);
  assign q_full  = (count_q == FULL_CNT);

  // No pass-through while full: a pop in the same cycle frees a slot that
  // only becomes fetchable on the following cycle. Reset and redirect both
  // suppress the push.
  assign fetch_fire = !q_full && !redirect_i && !rst_i;
  assign pop        = !q_empty && if_ready_i;

  // Sequential successor, wraps naturally at 32 bits.
  assign seq_pc = pc_q + INSTR_LEN;

  // The low two bits of the redirect target are always forced to zero.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  // --------------------------------------------------------------------------
  // Next-PC selection
  // --------------------------------------------------------------------------
`ifdef FETCH_BTFN_PRED_EN
  logic        is_bwd_branch;
  logic [31:0] br_offset;
  logic        mem_pred_q [QDEPTH];

  always_comb begin
    // B-type with a negative offset (sign bit = instr[31]) is predicted
    // taken; everything else falls through. EX owns recovery.
    is_bwd_branch = (instr_i[6:0] == 7'b1100011) && instr_i[31];
    br_offset     = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25],
                     instr_i[11:8], 1'b0};
    pred_taken    = is_bwd_branch;
    next_pc       = is_bwd_branch ? (pc_q + br_offset) : seq_pc;
  end

  always_ff @(posedge clk_i) begin
    if (fetch_fire) begin
      mem_pred_q[wr_ptr_q] <= pred_taken;
    end
  end

  assign if_pred_taken_o = mem_pred_q[rd_ptr_q];
`else
  assign pred_taken      = 1'b0;
  assign next_pc         = seq_pc;
  assign if_pred_taken_o = pred_taken;
`endif

  // --------------------------------------------------------------------------
  // Next-state logic for PC, pointers and occupancy
  // --------------------------------------------------------------------------
  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (redirect_i) begin
      // Flush: whatever decode takes this cycle is irrelevant, the queue
      // restarts empty and fetch resumes at the aligned target.
      pc_d     = {redirect_pc_i[31:2], 2'b00};
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (fetch_fire) begin
        pc_d     = next_pc;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      unique case ({fetch_fire, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // --------------------------------------------------------------------------
  // Queue storage write: capture the address and the instruction the cache
  // returned for it in the same cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (fetch_fire) begin
      mem_pc_q[wr_ptr_q]    <= pc_q;
      mem_instr_q[wr_ptr_q] <= instr_i;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign pc_o       = pc_q;
  assign if_valid_o = !q_empty;
  assign if_pc_o    = mem_pc_q[rd_ptr_q];
  assign if_instr_o = mem_instr_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Self-checking bench for fetch_stage. A queue-based reference
//            model tracks the expected PC and fetch-queue contents; directed
//            scenarios cover reset, streaming, back-pressure, redirect and
//            PC wrap, followed by a randomized run. The predictor scenario is
//            included when FETCH_BTFN_PRED_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          QDEPTH   = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] pc_o;
  logic [31:0] instr_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        if_valid_o;
  logic        if_ready_i;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;
  logic        if_pred_taken_o;

  fetch_stage #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .pc_o            (pc_o),
    .instr_i         (instr_i),
    .redirect_i      (redirect_i),
    .redirect_pc_i   (redirect_pc_i),
    .if_valid_o      (if_valid_o),
    .if_ready_i      (if_ready_i),
    .if_pc_o         (if_pc_o),
    .if_instr_o      (if_instr_o),
    .if_pred_taken_o (if_pred_taken_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: expected PC register and queue of fetched entries.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;

  // Instruction cache contents: explicit program words, else a hashed filler.
  logic [31:0] prog [logic [31:0]];
  logic [31:0] salt    = 32'h0;
  bit          branchy = 1'b0;

  function automatic logic [31:0] cache_rd(input logic [31:0] a);
    logic [31:0] h;
    if (prog.exists(a)) return prog[a];
    h = (a * 32'h9E37_79B1) ^ salt;
    if (branchy && h[2:0] == 3'd0) return {h[31:7], 7'b1100011};
    return {h[31:7], 7'b0010011};
  endfunction

  // Where fetch goes after pc holding instr, and whether it was a prediction.
  function automatic void predict(input logic [31:0] pc, input logic [31:0] instr,
                                  output logic [31:0] nxt, output logic p);
    logic signed [12:0] off;
    nxt = pc + 32'd4;
    p   = 1'b0;
`ifdef FETCH_BTFN_PRED_EN
    off = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    if (instr[6:0] == 7'h63 && off < 0) begin
      nxt = pc + 32'($signed(off));
      p   = 1'b1;
    end
`else
    off = '0;
    if (off != 0 || instr == 32'hx) nxt = pc + 32'd4;
`endif
  endfunction

  // Advance model by the current inputs, then clock the DUT by one cycle.
  task automatic tick();
    logic [31:0] nxt;
    logic        p;
    bit          fire;
    bit          do_pop;
    instr_i = cache_rd(pc_o);
    if (rst_i) begin
      mq.delete();
      m_pc = RESET_PC;
    end else if (redirect_i) begin
      mq.delete();
      m_pc = {redirect_pc_i[31:2], 2'b00};
    end else begin
      fire   = (mq.size() < QDEPTH);
      do_pop = (mq.size() != 0) && if_ready_i;
      if (do_pop) void'(mq.pop_front());
      if (fire) begin
        predict(m_pc, cache_rd(m_pc), nxt, p);
        mq.push_back('{pc: m_pc, instr: cache_rd(m_pc), pred: p});
        m_pc = nxt;
      end
    end
    @(posedge clk_i);
    #1;
    instr_i = cache_rd(pc_o);
  endtask

  task automatic do_reset();
    rst_i         = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    if_ready_i    = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (pc_o !== 32'h0) $display("FAIL reset_pc: got %h expected %h", pc_o, 32'h0);
    else n_pass++;
    n_checks++;
    if (if_valid_o !== 1'b0) $display("FAIL reset_valid: got %b expected 0", if_valid_o);
    else n_pass++;
    tick();
    n_checks++;
    if (if_valid_o !== 1'b1) $display("FAIL reset_first_valid: got %b expected 1", if_valid_o);
    else n_pass++;
    n_checks++;
    if (if_pc_o !== 32'h0) $display("FAIL reset_first_pc: got %h expected %h", if_pc_o, 32'h0);
    else n_pass++;
  endtask

  task automatic test_stream();
    logic [31:0] exp_instr [3];
    exp_instr[0] = 32'h00c00093;
    exp_instr[1] = 32'h00e00193;
    exp_instr[2] = 32'h00a00293;
    for (int i = 0; i < 3; i++) prog[32'(4 * i)] = exp_instr[i];
    do_reset();
    if_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_checks++;
      if (pc_o !== 32'(4 * (k + 1)))
        $display("FAIL stream_pc[%0d]: got %h expected %h", k, pc_o, 32'(4 * (k + 1)));
      else n_pass++;
      n_checks++;
      if (if_valid_o !== 1'b1 || if_pc_o !== 32'(4 * k))
        $display("FAIL stream_head[%0d]: got v=%b pc=%h expected v=1 pc=%h",
                 k, if_valid_o, if_pc_o, 32'(4 * k));
      else n_pass++;
      if (k < 3) begin
        n_checks++;
        if (if_instr_o !== exp_instr[k])
          $display("FAIL stream_instr[%0d]: got %h expected %h", k, if_instr_o, exp_instr[k]);
        else n_pass++;
      end
    end
    prog.delete();
  endtask

  task automatic test_backpressure();
    do_reset();
    tick();
    tick();
    n_checks++;
    if (pc_o !== 32'h8 || if_pc_o !== 32'h0 || if_valid_o !== 1'b1)
      $display("FAIL bp_full: got pc=%h head=%h v=%b expected pc=8 head=0 v=1",
               pc_o, if_pc_o, if_valid_o);
    else n_pass++;
    tick();
    n_checks++;
    if (pc_o !== 32'h8) $display("FAIL bp_hold: got %h expected %h", pc_o, 32'h8);
    else n_pass++;
    if_ready_i = 1'b1;
    tick();
    if_ready_i = 1'b0;
    n_checks++;
    if (pc_o !== 32'h8 || if_pc_o !== 32'h4)
      $display("FAIL bp_pop_nopush: got pc=%h head=%h expected pc=8 head=4", pc_o, if_pc_o);
    else n_pass++;
    tick();
    n_checks++;
    if (pc_o !== 32'hC || if_pc_o !== 32'h4)
      $display("FAIL bp_resume: got pc=%h head=%h expected pc=c head=4", pc_o, if_pc_o);
    else n_pass++;
    if_ready_i = 1'b1;
    tick();
    n_checks++;
    if (if_pc_o !== mq[0].pc || pc_o !== m_pc)
      $display("FAIL bp_drain: got pc=%h head=%h expected pc=%h head=%h",
               pc_o, if_pc_o, m_pc, mq[0].pc);
    else n_pass++;
  endtask

  task automatic test_redirect();
    do_reset();
    tick();
    tick();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h40;
    tick();
    redirect_i = 1'b0;
    n_checks++;
    if (if_valid_o !== 1'b0 || pc_o !== 32'h40)
      $display("FAIL redir_full: got v=%b pc=%h expected v=0 pc=40", if_valid_o, pc_o);
    else n_pass++;
    tick();
    n_checks++;
    if (if_valid_o !== 1'b1 || if_pc_o !== 32'h40 || pc_o !== 32'h44)
      $display("FAIL redir_refill: got v=%b head=%h pc=%h expected v=1 head=40 pc=44",
               if_valid_o, if_pc_o, pc_o);
    else n_pass++;
    // Redirect with a same-cycle pop; unaligned target.
    if_ready_i    = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h42;
    tick();
    redirect_i = 1'b0;
    if_ready_i = 1'b0;
    n_checks++;
    if (if_valid_o !== 1'b0 || pc_o !== 32'h40)
      $display("FAIL redir_align: got v=%b pc=%h expected v=0 pc=40", if_valid_o, pc_o);
    else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    if_ready_i    = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0;
    n_checks++;
    if (pc_o !== 32'hFFFF_FFFC) $display("FAIL wrap_start: got %h expected fffffffc", pc_o);
    else n_pass++;
    tick();
    n_checks++;
    if (pc_o !== 32'h0 || if_pc_o !== 32'hFFFF_FFFC || if_valid_o !== 1'b1)
      $display("FAIL wrap_next: got pc=%h head=%h v=%b expected pc=0 head=fffffffc v=1",
               pc_o, if_pc_o, if_valid_o);
    else n_pass++;
  endtask

`ifdef FETCH_BTFN_PRED_EN
  task automatic test_btfn();
    prog[32'h9C] = 32'hfc0006e3;
    prog[32'h7C] = 32'h00945863;
    do_reset();
    if_ready_i    = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h9C;
    tick();
    redirect_i = 1'b0;
    tick();
    n_checks++;
    if (pc_o !== 32'h68 || if_pc_o !== 32'h9C || if_pred_taken_o !== 1'b1)
      $display("FAIL btfn_bwd: got pc=%h head=%h pred=%b expected pc=68 head=9c pred=1",
               pc_o, if_pc_o, if_pred_taken_o);
    else n_pass++;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h7C;
    tick();
    redirect_i = 1'b0;
    tick();
    n_checks++;
    if (pc_o !== 32'h80 || if_pc_o !== 32'h7C || if_pred_taken_o !== 1'b0)
      $display("FAIL btfn_fwd: got pc=%h head=%h pred=%b expected pc=80 head=7c pred=0",
               pc_o, if_pc_o, if_pred_taken_o);
    else n_pass++;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h9C;
    tick();
    redirect_pc_i = 32'h200;
    tick();
    redirect_i = 1'b0;
    n_checks++;
    if (pc_o !== 32'h200 || if_valid_o !== 1'b0)
      $display("FAIL btfn_redir_wins: got pc=%h v=%b expected pc=200 v=0", pc_o, if_valid_o);
    else n_pass++;
    prog.delete();
  endtask
`endif

  task automatic test_random();
    salt    = $urandom;
    branchy = 1'b1;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst_i         = ($urandom_range(0, 199) == 0);
      redirect_i    = ($urandom_range(0, 99) < 8);
      redirect_pc_i = $urandom;
      if_ready_i    = ($urandom_range(0, 3) != 0);
      tick();
      n_checks++;
      if (pc_o !== m_pc) $display("FAIL rand_pc[%0d]: got %h expected %h", c, pc_o, m_pc);
      else n_pass++;
      n_checks++;
      if (if_valid_o !== (mq.size() != 0))
        $display("FAIL rand_valid[%0d]: got %b expected %b", c, if_valid_o, mq.size() != 0);
      else n_pass++;
      if (mq.size() != 0) begin
        n_checks++;
        if ({if_pc_o, if_instr_o, if_pred_taken_o} !== mq[0])
          $display("FAIL rand_head[%0d]: got %h/%h/%b expected %h/%h/%b", c,
                   if_pc_o, if_instr_o, if_pred_taken_o, mq[0].pc, mq[0].instr, mq[0].pred);
        else n_pass++;
      end
    end
    rst_i      = 1'b0;
    redirect_i = 1'b0;
    branchy    = 1'b0;
  endtask

  initial begin
    rst_i         = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    if_ready_i    = 1'b0;
    instr_i       = 32'h0;
    m_pc          = RESET_PC;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
`ifdef FETCH_BTFN_PRED_EN
    test_btfn();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
